// File: rtl/dma_sched.sv
// Layer DMA scheduler: fetches per-layer parameters, then per-tile FMI loads and compute launches in raster order.
// Optional watchdog on stalled DMA/compute handshakes enabled by defining DMA_SCHED_TIMEOUT_EN.
module dma_sched (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] n_tx,
    input  logic [7:0] n_ty,
    input  logic [7:0] tile_w,
    input  logic [7:0] tile_h,
    output logic       s_op,
    output logic [2:0] op,
    output logic [7:0] tx_i,
    output logic [7:0] ty_i,
    output logic [7:0] x_mem_i,
    output logic [7:0] y_mem_i,
    input  logic       e_op,
    output logic       comp_start,
    input  logic       comp_done,
    output logic       busy,
    output logic       done,
    output logic       err
);

    typedef enum logic [2:0] {
        IDLE, LD_INF, LD_KEXP, LD_KPW, LD_FMI, COMP, NEXT, FIN
    } state_t;

    localparam logic [2:0] OP_INF  = 3'd0;
    localparam logic [2:0] OP_KEXP = 3'd1;
    localparam logic [2:0] OP_KPW  = 3'd2;
    localparam logic [2:0] OP_FMI  = 3'd3;

    state_t     state;
    logic [7:0] n_tx_q, n_ty_q, tile_w_q, tile_h_q;
    logic [7:0] tx, ty;
    logic [7:0] x_off, y_off;

    logic       last_col, last_row, layer_end;
    logic [7:0] tx_nxt, ty_nxt, x_nxt, y_nxt;

    // Offsets are accumulated rather than multiplied; mod-256 wrap matches (t*w)[7:0].
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        last_col  = (tx == n_tx_q - 8'd1);
        last_row  = (ty == n_ty_q - 8'd1);
        layer_end = last_col && last_row;
        tx_nxt    = tx + 8'd1;
        ty_nxt    = ty;
        x_nxt     = x_off + tile_w_q;
        y_nxt     = y_off;
        if (last_col) begin
            tx_nxt = 8'd0;
            ty_nxt = ty + 8'd1;
            x_nxt  = 8'd0;
            y_nxt  = y_off + tile_h_q;
        end
    end

`ifdef DMA_SCHED_TIMEOUT_EN
    logic [15:0] wd;
    logic        err_q;
    logic        counting;

    assign counting = s_op || (state == COMP);
    assign err      = err_q;
`else
    assign err = 1'b0;
`endif

    // NOTE: all sequential state uses non-blocking assignments; later assignments in the block override defaults.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            n_tx_q     <= '0;
            n_ty_q     <= '0;
            tile_w_q   <= '0;
            tile_h_q   <= '0;
            tx         <= '0;
            ty         <= '0;
            x_off      <= '0;
            y_off      <= '0;
            s_op       <= 1'b0;
            op         <= OP_INF;
            tx_i       <= '0;
            ty_i       <= '0;
            x_mem_i    <= '0;
            y_mem_i    <= '0;
            comp_start <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
`ifdef DMA_SCHED_TIMEOUT_EN
            wd         <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            comp_start <= 1'b0;
            done       <= 1'b0;
`ifdef DMA_SCHED_TIMEOUT_EN
            wd <= counting ? wd + 16'd1 : 16'd0;
`endif
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= LD_INF;
                        n_tx_q   <= n_tx;
                        n_ty_q   <= n_ty;
                        tile_w_q <= tile_w;
                        tile_h_q <= tile_h;
                        tx       <= '0;
                        ty       <= '0;
                        x_off    <= '0;
                        y_off    <= '0;
                        op       <= OP_INF;
                        busy     <= 1'b1;
`ifdef DMA_SCHED_TIMEOUT_EN
                        wd       <= '0;
                        err_q    <= 1'b0;
`endif
                    end
                end

                LD_INF, LD_KEXP, LD_KPW, LD_FMI: begin
                    // First cycle in each load state keeps s_op low, guaranteeing a gap between requests.
                    if (!s_op) begin
                        s_op <= 1'b1;
                    end else if (e_op) begin
                        s_op <= 1'b0;
`ifdef DMA_SCHED_TIMEOUT_EN
                        wd   <= '0;
`endif
                        case (state)
                            LD_INF: begin
                                state <= LD_KEXP;
                                op    <= OP_KEXP;
                            end
                            LD_KEXP: begin
                                state <= LD_KPW;
                                op    <= OP_KPW;
                            end
                            LD_KPW: begin
                                if (n_tx_q == 8'd0 || n_ty_q == 8'd0) begin
                                    state <= FIN;
                                    op    <= OP_INF;
                                    done  <= 1'b1;
                                end else begin
                                    state <= LD_FMI;
                                    op    <= OP_FMI;
                                end
                            end
                            default: begin
                                state      <= COMP;
                                op         <= OP_INF;
                                tx_i       <= '0;
                                ty_i       <= '0;
                                x_mem_i    <= '0;
                                y_mem_i    <= '0;
                                comp_start <= 1'b1;
                            end
                        endcase
                    end
                end

                COMP: begin
                    if (comp_done) begin
                        state <= NEXT;
`ifdef DMA_SCHED_TIMEOUT_EN
                        wd    <= '0;
`endif
                    end
                end

                NEXT: begin
                    tx    <= tx_nxt;
                    ty    <= ty_nxt;
                    x_off <= x_nxt;
                    y_off <= y_nxt;
                    if (layer_end) begin
                        state <= FIN;
                        done  <= 1'b1;
                    end else begin
                        state   <= LD_FMI;
                        op      <= OP_FMI;
                        tx_i    <= tx_nxt;
                        ty_i    <= ty_nxt;
                        x_mem_i <= x_nxt;
                        y_mem_i <= y_nxt;
                    end
                end

                FIN: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase

`ifdef DMA_SCHED_TIMEOUT_EN
            // A stalled handshake abandons the layer; err holds until reset or the next start.
            if (counting && wd == 16'hFFFF) begin
                state      <= IDLE;
                err_q      <= 1'b1;
                s_op       <= 1'b0;
                op         <= OP_INF;
                tx_i       <= '0;
                ty_i       <= '0;
                x_mem_i    <= '0;
                y_mem_i    <= '0;
                comp_start <= 1'b0;
                busy       <= 1'b0;
                done       <= 1'b0;
                wd         <= '0;
            end
`endif
        end
    end

endmodule

// File: doc/dma_sched.md
DMA_SCHED -- requirements
Module: dma_sched

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: rst  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port: start  input  1  begin layer; sampled only in IDLE.
REQ-004 SHALL have port: n_tx  input  8  tile count in x; n_ty  input  8  tile count in y; latched at start.
REQ-005 SHALL have port: tile_w  input  8  tile width; tile_h  input  8  tile height; latched at start.
REQ-006 SHALL have port: s_op  output  1  DMA operation request (level).
REQ-007 SHALL have port: op  output  3  DMA opcode: 0 inf_conv, 1 kexp, 2 kpw, 3 fmi tile.
REQ-008 SHALL have port: tx_i, ty_i, x_mem_i, y_mem_i  output  8 each  DMA tile index and memory offset.
REQ-009 SHALL have port: e_op  input  1  DMA operation end.
REQ-010 SHALL have port: comp_start  output  1  one-cycle compute launch; comp_done  input  1  compute finished.
REQ-011 SHALL have port: busy  output  1  high outside IDLE; done  output  1  one-cycle layer-complete pulse; err  output  1  sticky timeout flag.

Function
REQ-012 SHALL implement states IDLE, LD_INF, LD_KEXP, LD_KPW, LD_FMI, COMP, NEXT, FIN.
REQ-013 SHALL leave IDLE for LD_INF on the edge where start=1, latching n_tx, n_ty, tile_w, tile_h, clearing tx/ty to 0.
REQ-014 SHALL assert s_op, with op set to the state's code, from the cycle after entering an LD_* state until e_op is sampled high.
REQ-015 SHALL drive s_op low the cycle after e_op is sampled, then move to the next state; consecutive s_op pulses are separated by at least one low cycle.
REQ-016 SHALL hold op, tx_i, ty_i, x_mem_i, y_mem_i stable while s_op=1.
REQ-017 SHALL ignore e_op outside LD_* states and while s_op=0.
REQ-018 SHALL sequence LD_INF -> LD_KEXP -> LD_KPW -> LD_FMI; if latched n_tx=0 or n_ty=0, LD_KPW goes directly to FIN.
REQ-019 SHALL drive tx_i=tx, ty_i=ty, x_mem_i=(tx*tile_w)[7:0], y_mem_i=(ty*tile_h)[7:0] during LD_FMI; all four are 0 in other states.
REQ-020 SHALL pulse comp_start for exactly one cycle on entering COMP, then wait for comp_done=1.
REQ-021 SHALL in NEXT advance raster order: tx+1; on tx=n_tx-1, tx=0 and ty+1; after tx=n_tx-1 and ty=n_ty-1, go to FIN; otherwise go to LD_FMI.
REQ-022 SHALL pulse done for one cycle in FIN and return to IDLE on the next edge.
REQ-023 SHALL ignore start in every state except IDLE, including a start coinciding with done.
REQ-024 SHALL keep busy=1 in all states except IDLE.

Reset
REQ-025 SHALL, on rst=0 at any time, including mid-transfer, immediately force IDLE and drive s_op=0, op=0, tx_i=ty_i=x_mem_i=y_mem_i=0, comp_start=0, busy=0, done=0, err=0.
REQ-026 SHALL clear latched counts and tile counters on reset; a DMA transfer left outstanding is abandoned.

Configuration
REQ-027 SHALL, with DMA_SCHED_TIMEOUT_EN defined, run a 16-bit watchdog counting cycles while s_op=1 or in COMP, cleared on each state change.
REQ-028 SHALL, with DMA_SCHED_TIMEOUT_EN defined, set err=1 and go to IDLE when the watchdog reaches 65535; err stays set until reset or the next accepted start.
REQ-029 SHALL, without DMA_SCHED_TIMEOUT_EN, omit the watchdog, tie err to 0 and wait indefinitely for e_op and comp_done.

Verification
REQ-030 SHALL cover basic layer: n_tx=2, n_ty=1, tile_w=22, DMA model answers e_op 5 cycles after s_op -> op sequence 0,1,2,3,3; FMI tiles (tx,x_mem)=(0,0),(1,22); 2 comp_start pulses; one done pulse.
REQ-031 SHALL cover raster wrap: n_tx=3, n_ty=2, tile_h=10 -> FMI order (0,0),(1,0),(2,0),(0,1),(1,1),(2,1); y_mem_i=10 on row 1.
REQ-032 SHALL cover zero tiles: n_tx=0, n_ty=4 -> ops 0,1,2 only, no comp_start, done one cycle after the KPW transfer completes.
REQ-033 SHALL cover offset wrap: tx=23, tile_w=22 -> x_mem_i=(506 mod 256)=250.
REQ-034 SHALL cover reset mid-op: rst=0 while s_op=1 with op=3 -> all outputs 0 within the same cycle; after release, start restarts at op=0.
REQ-035 SHALL cover timeout with DMA_SCHED_TIMEOUT_EN: e_op never returned -> err=1, busy=0 after 65535 cycles; without the macro, busy stays 1 and err stays 0.
